pio_sequencer: RTL

- Sits upstream of the LVDA; models the LVDC computer side of a Process Input/Output (PIO) transfer.
- Generates the free-running four-phase timing pulses WDA/XDA/YDA/ZDA.
- Sequences one PIO command at a time: drives the address lines A1V–A9V, AI3V and TRSV, then strobes PIOV in bit-time-aligned windows.
- Commands are accepted from a testbench or a future CPU model through a valid/ready handshake.

---
 rtl/pio_pkg.sv | 38 +++
 rtl/pio_sequencer_if.sv | 13 +
 rtl/phase_gen.sv | 59 +++++
 rtl/pio_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared types for the PIO sequencer and its phase generator.
package pio_pkg;

  localparam int unsigned NUM_PHASES = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_e;

  typedef enum logic [$clog2(NUM_PHASES)-1:0] {
    PH_W,
    PH_X,
    PH_Y,
    PH_Z
  } phase_e;

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_W:    return PH_X;
      PH_X:    return PH_Y;
      PH_Y:    return PH_Z;
      default: return PH_W;
    endcase
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pio_sequencer_if.sv
// Command handshake between a command source and the PIO sequencer.
interface pio_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [8:0] req_addr;
  logic       req_ai3;
  logic       req_trs;

  modport master (output req_valid, output req_addr, output req_ai3, output req_trs,
                  input req_ready);
  modport slave  (input req_valid, input req_addr, input req_ai3, input req_trs,
                  output req_ready);
endinterface

// File: rtl/phase_gen.sv
// Free-running four-phase W/X/Y/Z generator; bb_o marks the last clock of Z.
module phase_gen
  import pio_pkg::*;
#(
  parameter int unsigned PHASE_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic wda_o,
  output logic xda_o,
  output logic yda_o,
  output logic zda_o,
  output logic bb_o
);
  localparam int unsigned CW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHASE_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  phase_e        ph_q, ph_d;
  logic          run_q;
  logic          last;

  assign last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (run_q) begin
      if (last) begin
        cnt_d = '0;
        ph_d  = next_phase(ph_q);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // run_q keeps every phase low in the reset cycle so W begins on the first edge after release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      ph_q  <= PH_W;
    end else begin
      run_q <= 1'b1;
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

  always_comb begin
    wda_o = run_q && (ph_q == PH_W);
    xda_o = run_q && (ph_q == PH_X);
    yda_o = run_q && (ph_q == PH_Y);
    zda_o = run_q && (ph_q == PH_Z);
    bb_o  = run_q && (ph_q == PH_Z) && last;
  end

endmodule

// File: rtl/pio_sequencer.sv
// LVDC-side PIO transfer sequencer: bit-aligned address setup, PIOV strobe and hold.
// Optional odd-parity output APARV when PIO_PARITY_EN is defined.
module pio_sequencer
  import pio_pkg::*;
#(
  parameter int unsigned PHASE_LEN   = 4,
  parameter int unsigned SETUP_BITS  = 1,
  parameter int unsigned STROBE_BITS = 2,
  parameter int unsigned HOLD_BITS   = 1
) (
  input  logic           SIM_CLK,
  input  logic           SIM_RST,
  pio_sequencer_if.slave cmd,
  output logic           A1V,
  output logic           A2V,
  output logic           A3V,
  output logic           A4V,
  output logic           A5V,
  output logic           A6V,
  output logic           A7V,
  output logic           A8V,
  output logic           A9V,
  output logic           AI3V,
  output logic           TRSV,
  output logic           PIOV,
  output logic           WDA,
  output logic           XDA,
  output logic           YDA,
  output logic           ZDA,
  output logic           done
`ifdef PIO_PARITY_EN
  ,
  output logic           APARV
`endif
);
  localparam int unsigned MAX_BITS = max3(SETUP_BITS, STROBE_BITS, HOLD_BITS);
  localparam int unsigned BW       = $clog2(MAX_BITS + 1);
  localparam logic [BW-1:0] SETUP_LD  = BW'(SETUP_BITS - 1);
  localparam logic [BW-1:0] STROBE_LD = BW'(STROBE_BITS - 1);
  localparam logic [BW-1:0] HOLD_LD   = (HOLD_BITS > 0) ? BW'(HOLD_BITS - 1) : '0;

  state_e        state_q, state_d;
  logic [BW-1:0] bits_q, bits_d;
  logic          ready_q;
  logic [10:0]   cmd_q;
  logic [10:0]   lines_q;
  logic          accept, load_lines, clr_lines, bb;

  phase_gen #(.PHASE_LEN(PHASE_LEN)) u_phase (
    .clk_i (SIM_CLK),
    .rst_i (SIM_RST),
    .wda_o (WDA),
    .xda_o (XDA),
    .yda_o (YDA),
    .zda_o (ZDA),
    .bb_o  (bb)
  );

  assign cmd.req_ready = ready_q;

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q <= IDLE;
      bits_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      ready_q <= (state_d == IDLE);
    end
  end

  // Each bit-counting state reloads on entry and advances only on bit boundaries.
  always_comb begin
    state_d    = state_q;
    bits_d     = bits_q;
    accept     = 1'b0;
    load_lines = 1'b0;
    clr_lines  = 1'b0;
    case (state_q)
      IDLE: begin
        accept = cmd.req_valid && ready_q;
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (bb) begin
          state_d    = SETUP;
          bits_d     = SETUP_LD;
          load_lines = 1'b1;
        end
      end
      SETUP: begin
        if (bb) begin
          if (bits_q == '0) begin
            state_d = STROBE;
            bits_d  = STROBE_LD;
          end else begin
            bits_d = bits_q - 1'b1;
          end
        end
      end
      STROBE: begin
        if (bb) begin
          if (bits_q == '0) begin
            state_d = (HOLD_BITS == 0) ? DONE : HOLD;
            bits_d  = HOLD_LD;
          end else begin
            bits_d = bits_q - 1'b1;
          end
        end
      end
      HOLD: begin
        if (bb) begin
          if (bits_q == '0) state_d = DONE;
          else              bits_d  = bits_q - 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        clr_lines = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      cmd_q   <= '0;
      lines_q <= '0;
    end else begin
      if (accept)          cmd_q   <= {cmd.req_trs, cmd.req_ai3, cmd.req_addr};
      if (load_lines)      lines_q <= cmd_q;
      else if (clr_lines)  lines_q <= '0;
    end
  end

`ifdef PIO_PARITY_EN
  logic apar_q;

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST)         apar_q <= 1'b1;
    else if (load_lines) apar_q <= ~^cmd_q[9:0];
    else if (clr_lines)  apar_q <= 1'b1;
  end

  assign APARV = apar_q;
`endif

  always_comb begin
    PIOV = (state_q == STROBE);
    done = (state_q == DONE);
    {TRSV, AI3V, A9V, A8V, A7V, A6V, A5V, A4V, A3V, A2V, A1V} = lines_q;
  end

endmodule
